// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: funct3 access-size codes, LSU FSM states, datapath width.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: byte enables and replicated store data, plus load lane select and extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_raw,
    output logic [3:0]      be,
    output logic [XLEN-1:0] store_lanes,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = load_raw[7:0];
        case (offset)
            2'd1:    byte_sel = load_raw[15:8];
            2'd2:    byte_sel = load_raw[23:16];
            2'd3:    byte_sel = load_raw[31:24];
            default: byte_sel = load_raw[7:0];
        endcase
        half_sel = offset[1] ? load_raw[31:16] : load_raw[15:0];
    end

    // Undefined funct3 codes fall through to the word case.
    always_comb begin
        be          = 4'b1111;
        store_lanes = store_data;
        load_data   = load_raw;
        case (funct3)
            F3_B, F3_BU: begin
                be          = 4'b0001 << offset;
                store_lanes = {4{store_data[7:0]}};
                load_data   = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                               : {24'h0, byte_sel};
            end
            F3_H, F3_HU: begin
                be          = offset[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
                load_data   = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                               : {16'h0, half_sel};
            end
            default: begin
                be          = 4'b1111;
                store_lanes = store_data;
                load_data   = load_raw;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: registered request/ready handshake to data memory, stalling the pipeline while busy.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and flag misalign_M for one cycle.
module mem_stage_lsu #(
    parameter int XLEN  = 32,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_mem_read_M,
    input  logic             ctrl_mem_write_M,
    input  logic [2:0]       funct3_M,
    input  logic [XLEN-1:0]  ALU_result_M,
    input  logic [XLEN-1:0]  write_data_M,
    output logic [XLEN-1:0]  data_memory_RD_M,
    output logic             stall_M,
    output logic             misalign_M,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic [LANES-1:0] dmem_be,
    input  logic             dmem_ready,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic [1:0]       lsu_state
);
    import riscv_pkg::*;

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_DONE   = DONE;

    // Handshake: dmem_req rises with address/data/be/we already valid and all of
    // them stay frozen until the cycle dmem_ready=1 is seen; that edge completes
    // the access and drops dmem_req. dmem_rdata is sampled only at that edge.

    logic [1:0]  state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        load_q;
    logic        both_q;
    logic        mem_op;
    logic        trap;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic [3:0]  ld_be_nc;
    logic [31:0] ld_wdata_nc;
    logic [31:0] st_load_nc;
    logic        unused_align;

    assign mem_op    = ctrl_mem_read_M | ctrl_mem_write_M;
    assign stall_M   = ((state == S_IDLE) & mem_op) | (state == S_ACCESS);
    assign lsu_state = state;

`ifdef MISALIGN_TRAP_EN
    logic is_byte;
    logic is_half;
    assign is_byte = (funct3_M == F3_B) | (funct3_M == F3_BU);
    assign is_half = (funct3_M == F3_H) | (funct3_M == F3_HU);
    assign trap    = (is_half & ALU_result_M[0]) |
                     (~is_byte & ~is_half & (ALU_result_M[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    lsu_align u_store_align (
        .funct3      (funct3_M),
        .offset      (ALU_result_M[1:0]),
        .store_data  (write_data_M),
        .load_raw    (dmem_rdata),
        .be          (st_be),
        .store_lanes (st_wdata),
        .load_data   (st_load_nc)
    );

    // The load side uses the size/offset latched at issue, not the live M inputs.
    lsu_align u_load_align (
        .funct3      (f3_q),
        .offset      (off_q),
        .store_data  (32'h0),
        .load_raw    (dmem_rdata),
        .be          (ld_be_nc),
        .store_lanes (ld_wdata_nc),
        .load_data   (ld_data)
    );

    assign unused_align = ^{ld_be_nc, ld_wdata_nc, st_load_nc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= '0;
            dmem_wdata       <= '0;
            dmem_be          <= '0;
            data_memory_RD_M <= '0;
            misalign_M       <= 1'b0;
            f3_q             <= 3'b000;
            off_q            <= 2'b00;
            load_q           <= 1'b0;
            both_q           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_op && trap) begin
                        misalign_M       <= 1'b1;
                        data_memory_RD_M <= '0;
                        state            <= S_DONE;
                    end else if (mem_op) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= ctrl_mem_write_M;
                        dmem_addr  <= {ALU_result_M[XLEN-1:2], 2'b00};
                        dmem_wdata <= st_wdata;
                        dmem_be    <= st_be;
                        f3_q       <= funct3_M;
                        off_q      <= ALU_result_M[1:0];
                        load_q     <= ctrl_mem_read_M & ~ctrl_mem_write_M;
                        both_q     <= ctrl_mem_read_M & ctrl_mem_write_M;
                        state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (load_q) begin
                            data_memory_RD_M <= ld_data;
                        end else if (both_q) begin
                            data_memory_RD_M <= '0;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // The instruction is still on the M inputs here; going back to
                    // IDLE only after this cycle keeps it from being re-issued.
                    misalign_M <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed, table-driven bench for mem_stage_lsu with a variable-latency memory responder.
module tb_mem_stage_lsu;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_mem_read_M;
    logic        ctrl_mem_write_M;
    logic [2:0]  funct3_M;
    logic [31:0] ALU_result_M;
    logic [31:0] write_data_M;
    logic [31:0] data_memory_RD_M;
    logic        stall_M;
    logic        misalign_M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [1:0]  lsu_state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          wait_n;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
        int          exp_stall;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32), .LANES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .ctrl_mem_read_M  (ctrl_mem_read_M),
        .ctrl_mem_write_M (ctrl_mem_write_M),
        .funct3_M         (funct3_M),
        .ALU_result_M     (ALU_result_M),
        .write_data_M     (write_data_M),
        .data_memory_RD_M (data_memory_RD_M),
        .stall_M          (stall_M),
        .misalign_M       (misalign_M),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_be          (dmem_be),
        .dmem_ready       (dmem_ready),
        .dmem_rdata       (dmem_rdata),
        .lsu_state        (lsu_state)
    );

    function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wd, logic [31:0] rdata, int wait_n,
                                logic [31:0] exp_addr, logic [3:0] exp_be, logic exp_we,
                                logic [31:0] exp_wdata, logic [31:0] exp_rd, int exp_stall);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
        v.wait_n = wait_n; v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_we = exp_we;
        v.exp_wdata = exp_wdata; v.exp_rd = exp_rd; v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ctrl_mem_read_M  = 1'b0;
        ctrl_mem_write_M = 1'b0;
        funct3_M         = F3_W;
        ALU_result_M     = 32'h0000_0700;
        write_data_M     = 32'h0;
    endtask

    // Called just after a rising edge with the LSU in IDLE.
    task automatic run_op(input vec_t v, input string tag);
        int  stalls = 0;
        int  waited = 0;
        bit  done   = 1'b0;
        ctrl_mem_read_M  = v.rd;
        ctrl_mem_write_M = v.wr;
        funct3_M         = v.f3;
        ALU_result_M     = v.addr;
        write_data_M     = v.wd;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall_M) stalls++;
            if (lsu_state == ACCESS) begin
                check($sformatf("%s req", tag),   {31'h0, dmem_req}, 32'h1);
                check($sformatf("%s addr", tag),  dmem_addr, v.exp_addr);
                check($sformatf("%s be", tag),    {28'h0, dmem_be}, {28'h0, v.exp_be});
                check($sformatf("%s we", tag),    {31'h0, dmem_we}, {31'h0, v.exp_we});
                check($sformatf("%s wdata", tag), dmem_wdata, v.exp_wdata);
                if (waited == v.wait_n) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = v.rdata;
                end else begin
                    waited++;
                end
            end else if (lsu_state == DONE) begin
                check($sformatf("%s rd", tag),       data_memory_RD_M, v.exp_rd);
                check($sformatf("%s done_req", tag), {31'h0, dmem_req}, 32'h0);
                check($sformatf("%s misalign", tag), {31'h0, misalign_M}, 32'h0);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            dmem_ready = 1'b0;
            dmem_rdata = 32'h5A5A_5A5A;
        end
        if (!done) check($sformatf("%s timeout", tag), 32'h0, 32'h1);
        check($sformatf("%s stall_cycles", tag), stalls, v.exp_stall);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] last_rd;

        //        rd wr f3     addr          wd            rdata         w  exp_addr      be       we  exp_wdata     exp_rd        stall
        vecs[0]  = mk(1, 0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 0, 32'h100, 4'b1111, 0, 32'h0,        32'hDEADBEEF, 2);
        vecs[1]  = mk(1, 0, F3_B,  32'h103, 32'h0,        32'h80FF0000, 0, 32'h100, 4'b1000, 0, 32'h0,        32'hFFFFFF80, 2);
        vecs[2]  = mk(1, 0, F3_BU, 32'h103, 32'h0,        32'h80FF0000, 0, 32'h100, 4'b1000, 0, 32'h0,        32'h00000080, 2);
        vecs[3]  = mk(0, 1, F3_H,  32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 3, 32'h200, 4'b1100, 1, 32'hABCDABCD, 32'h00000080, 5);
        vecs[4]  = mk(1, 0, F3_H,  32'h102, 32'h0,        32'h80017FFF, 1, 32'h100, 4'b1100, 0, 32'h0,        32'hFFFF8001, 3);
        vecs[5]  = mk(1, 0, F3_HU, 32'h100, 32'h0,        32'h80017FFF, 0, 32'h100, 4'b0011, 0, 32'h0,        32'h00007FFF, 2);
        vecs[6]  = mk(0, 1, F3_B,  32'h301, 32'h000000A5, 32'h12345678, 2, 32'h300, 4'b0010, 1, 32'hA5A5A5A5, 32'h00007FFF, 4);
        vecs[7]  = mk(0, 1, F3_W,  32'h400, 32'hCAFEF00D, 32'h0,        0, 32'h400, 4'b1111, 1, 32'hCAFEF00D, 32'h00007FFF, 2);
        vecs[8]  = mk(1, 0, 3'b011,32'h500, 32'h0,        32'h11223344, 0, 32'h500, 4'b1111, 0, 32'h0,        32'h11223344, 2);
        vecs[9]  = mk(1, 1, F3_W,  32'h600, 32'h00000055, 32'hAAAAAAAA, 0, 32'h600, 4'b1111, 1, 32'h00000055, 32'h00000000, 2);
        vecs[10] = mk(1, 0, F3_B,  32'h101, 32'h0,        32'h00007F00, 0, 32'h100, 4'b0010, 0, 32'h0,        32'h0000007F, 2);
        vecs[11] = mk(1, 0, F3_HU, 32'h102, 32'h0,        32'hF00D1234, 1, 32'h100, 4'b1100, 0, 32'h0,        32'h0000F00D, 3);

        // Reset state
        rst        = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset state",  {30'h0, lsu_state}, {30'h0, IDLE});
        check("reset req",    {31'h0, dmem_req}, 32'h0);
        check("reset we",     {31'h0, dmem_we}, 32'h0);
        check("reset addr",   dmem_addr, 32'h0);
        check("reset wdata",  dmem_wdata, 32'h0);
        check("reset be",     {28'h0, dmem_be}, 32'h0);
        check("reset rd",     data_memory_RD_M, 32'h0);
        check("reset misal",  {31'h0, misalign_M}, 32'h0);
        check("reset stall",  {31'h0, stall_M}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Non-memory instruction: no stall, no request, load result held
        last_rd = vecs[11].exp_rd;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("alu stall%0d", c), {31'h0, stall_M}, 32'h0);
            check($sformatf("alu req%0d", c),   {31'h0, dmem_req}, 32'h0);
            check($sformatf("alu rd%0d", c),    data_memory_RD_M, last_rd);
        end
        @(posedge clk);
        #1;
        run_op(vecs[0], "lw_after_alu");

        // Reset while an access is outstanding
        ctrl_mem_read_M = 1'b1;
        funct3_M        = F3_W;
        ALU_result_M    = 32'h800;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid in access", {30'h0, lsu_state}, {30'h0, ACCESS});
        check("rst_mid req",       {31'h0, dmem_req}, 32'h1);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        check("rst_mid state", {30'h0, lsu_state}, {30'h0, IDLE});
        check("rst_mid req0",  {31'h0, dmem_req}, 32'h0);
        check("rst_mid addr",  dmem_addr, 32'h0);
        check("rst_mid be",    {28'h0, dmem_be}, 32'h0);
        check("rst_mid rd",    data_memory_RD_M, 32'h0);
        check("rst_mid stall", {31'h0, stall_M}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(vecs[0], "lw_after_rst");

`ifdef MISALIGN_TRAP_EN
        // Misaligned word: no request, one stall cycle, flag in DONE only
        ctrl_mem_read_M = 1'b1;
        funct3_M        = F3_W;
        ALU_result_M    = 32'h101;
        @(negedge clk);
        check("mis stall", {31'h0, stall_M}, 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mis state",  {30'h0, lsu_state}, {30'h0, DONE});
        check("mis flag",   {31'h0, misalign_M}, 32'h1);
        check("mis req",    {31'h0, dmem_req}, 32'h0);
        check("mis rd",     data_memory_RD_M, 32'h0);
        check("mis stall0", {31'h0, stall_M}, 32'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        check("mis flag_clr", {31'h0, misalign_M}, 32'h0);
        check("mis req_idle", {31'h0, dmem_req}, 32'h0);
        @(posedge clk);
        #1;
`else
        // Misaligned word is truncated to the aligned word
        run_op(mk(1, 0, F3_W, 32'h101, 32'h0, 32'h0BADF00D, 0, 32'h100, 4'b1111, 0,
                  32'h0, 32'h0BADF00D, 2), "lw_misaligned");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
